// File: rtl/conv_out_sat_fifo.sv
// conv_out_sat_fifo: scale/saturate conv channels to RGB888, buffer in a FIFO, track raster position and clips
module conv_out_sat_fifo #(
  parameter int WIDTH = 32,
  parameter int HEIGHT = 32,
  parameter int DEPTH = 4,
  parameter int SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      conv_valid,
  input  logic [47:0]               pixel_out,
  output logic                      write_ready,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [23:0]               out_pixel,
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y,
  output logic                      frame_done,
  output logic [15:0]               clip_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [23:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ, occ_n;
  logic [8:0] sr, sg, sb;
  logic [1:0] clips;
  logic [16:0] csum;
  logic push, pop, last;
  // returns {clipped, byte} for one signed channel after the arithmetic shift
  function automatic logic [8:0] sat(input logic [15:0] ch);
    logic signed [15:0] v;
    v = $signed(ch) >>> SHIFT;
    return v < 16'sd0 ? 9'h100 : v > 16'sd255 ? 9'h1ff : {1'b0, v[7:0]};
  endfunction
  assign push = conv_valid & write_ready;
  assign pop = out_valid & out_ready;
  assign out_valid = occ != '0;
  assign out_pixel = out_valid ? mem[rd_ptr] : 24'h0;
  assign last = pop && out_x == X_LAST && out_y == Y_LAST;
  assign occ_n = occ + (AW + 1)'(push) - (AW + 1)'(pop);
  // per-channel saturation and clip tally for the incoming word
  always_comb begin
    sr = sat(pixel_out[47:32]);
    sg = sat(pixel_out[31:16]);
    sb = sat(pixel_out[15:0]);
    clips = {1'b0, sr[8]} + {1'b0, sg[8]} + {1'b0, sb[8]};
    csum = {1'b0, clip_cnt} + 17'(clips);
  end
  // storage has no reset; the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sr[7:0], sg[7:0], sb[7:0]};
  end
  // pointers, occupancy, coordinates, frame pulse and clip counter
  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      write_ready <= 1'b1;
      out_x <= '0;
      out_y <= '0;
      frame_done <= 1'b0;
      clip_cnt <= 16'h0;
    end else begin
      occ <= occ_n;
      write_ready <= occ_n != FULL;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) out_x <= out_x == X_LAST ? '0 : out_x + 1'b1;
      if (pop && out_x == X_LAST) out_y <= out_y == Y_LAST ? '0 : out_y + 1'b1;
      frame_done <= last;
      clip_cnt <= last ? (push ? 16'(clips) : 16'h0) : push ? (csum[16] ? 16'hFFFF : csum[15:0]) : clip_cnt;
    end
  end
endmodule

// File: tb/tb_conv_out_sat_fifo.sv
// tb_conv_out_sat_fifo: directed vectors plus handshake, raster, reset and clip-saturation sequences
module tb_conv_out_sat_fifo;
  logic clk = 1'b0, rstb, conv_valid, out_ready;
  logic [47:0] pixel_out;
  logic wr0, ov0, fd0, wr4, ov4, fd4, wrs, ovs, fds;
  logic [23:0] px0, px4, pxs;
  logic [4:0] x0, y0, x4, y4;
  logic [6:0] xs;
  logic [7:0] ys;
  logic [15:0] cc0, cc4, ccs;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  conv_out_sat_fifo #(.SHIFT(0)) dut0 (.clk(clk), .rstb(rstb), .conv_valid(conv_valid), .pixel_out(pixel_out),
    .write_ready(wr0), .out_ready(out_ready), .out_valid(ov0), .out_pixel(px0), .out_x(x0), .out_y(y0),
    .frame_done(fd0), .clip_cnt(cc0));
  conv_out_sat_fifo #(.SHIFT(4)) dut4 (.clk(clk), .rstb(rstb), .conv_valid(conv_valid), .pixel_out(pixel_out),
    .write_ready(wr4), .out_ready(out_ready), .out_valid(ov4), .out_pixel(px4), .out_x(x4), .out_y(y4),
    .frame_done(fd4), .clip_cnt(cc4));
  conv_out_sat_fifo #(.WIDTH(128), .HEIGHT(256)) duts (.clk(clk), .rstb(rstb), .conv_valid(conv_valid),
    .pixel_out(pixel_out), .write_ready(wrs), .out_ready(out_ready), .out_valid(ovs), .out_pixel(pxs),
    .out_x(xs), .out_y(ys), .frame_done(fds), .clip_cnt(ccs));

  typedef struct {
    logic [47:0] w;
    logic [23:0] p0;
    logic [15:0] c0;
    logic [23:0] p4;
    logic [15:0] c4;
  } vec_t;
  vec_t v[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstb = 1'b1;
    conv_valid = 1'b0;
    out_ready = 1'b0;
    pixel_out = '0;
    step;
    rstb = 1'b0;
  endtask

  function automatic logic [47:0] wd(input int n);
    logic [31:0] t;
    t = n;
    return {8'h00, t[7:0], 16'h0000, 8'h00, t[9:2]};
  endfunction

  function automatic logic [23:0] wp(input int n);
    logic [31:0] t;
    t = n;
    return {t[7:0], 8'h00, t[9:2]};
  endfunction

  task automatic stream(input int n, output int cyc);
    int pushes = 0, pops = 0;
    logic p, q;
    cyc = 0;
    conv_valid = 1'b1;
    out_ready = 1'b1;
    pixel_out = wd(0);
    while (pops < n && cyc < n + 50) begin
      p = conv_valid & wr0;
      q = ov0 & out_ready;
      if (q) begin
        chk("strm_px", px0, wp(pops));
        chk("strm_x", x0, pops % 32);
        chk("strm_y", y0, (pops / 32) % 32);
      end
      chk("strm_fd", fd0, 0);
      chk("strm_wr", wr0, 1);
      step;
      cyc++;
      if (p) pushes++;
      if (q) pops++;
      conv_valid = pushes < n;
      pixel_out = wd(pushes);
    end
    conv_valid = 1'b0;
    if (pops < n) chk("strm_timeout", pops, n);
  endtask

  initial begin
    int cyc, nfd;
    v[0] = '{48'h0064_FF9C_0200, 24'h64_00_FF, 16'd2, 24'h06_00_20, 16'd1};
    v[1] = '{48'h0FF0_1000_0008, 24'hFF_FF_08, 16'd2, 24'hFF_FF_00, 16'd1};
    v[2] = '{48'h00FF_0100_8000, 24'hFF_FF_00, 16'd2, 24'h0F_10_00, 16'd1};
    v[3] = '{48'h0000_0001_00FF, 24'h00_01_FF, 16'd0, 24'h00_00_0F, 16'd0};
    v[4] = '{48'h7FFF_FFFF_0010, 24'hFF_00_10, 16'd2, 24'hFF_00_01, 16'd2};

    for (int i = 0; i < 5; i++) begin
      do_reset;
      chk("rst_ov", ov0, 0);
      chk("rst_wr", wr0, 1);
      chk("rst_px", px0, 0);
      chk("rst_cc", cc0, 0);
      chk("rst_fd", fd0, 0);
      conv_valid = 1'b1;
      pixel_out = v[i].w;
      step;
      conv_valid = 1'b0;
      chk("vec_ov", ov0, 1);
      chk("vec_px0", px0, v[i].p0);
      chk("vec_cc0", cc0, v[i].c0);
      chk("vec_px4", px4, v[i].p4);
      chk("vec_cc4", cc4, v[i].c4);
      chk("vec_xy", {x0, y0}, 0);
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      chk("vec_pop_ov", ov0, 0);
      chk("vec_pop_x", x0, 1);
    end

    do_reset;
    for (int i = 0; i < 4; i++) begin
      conv_valid = 1'b1;
      pixel_out = wd(i * 7 + 3);
      step;
    end
    chk("full_wr", wr0, 0);
    chk("full_head", px0, wp(3));
    pixel_out = wd(4 * 7 + 3);
    step;
    chk("full_blk_wr", wr0, 0);
    chk("full_blk_head", px0, wp(3));
    chk("full_blk_ov", ov0, 1);
    out_ready = 1'b1;
    step;
    chk("drain1_px", px0, wp(1 * 7 + 3));
    chk("drain1_wr", wr0, 1);
    step;
    chk("drain2_px", px0, wp(2 * 7 + 3));
    conv_valid = 1'b0;
    step;
    chk("drain3_px", px0, wp(3 * 7 + 3));
    step;
    chk("drain4_px", px0, wp(4 * 7 + 3));
    step;
    chk("drain_empty", ov0, 0);

    do_reset;
    stream(1024, cyc);
    chk("thru_cycles", cyc, 1025);
    chk("frame_fd", fd0, 1);
    chk("frame_ov", ov0, 0);
    chk("frame_xy", {x0, y0}, 0);
    step;
    chk("frame_fd_off", fd0, 0);

    do_reset;
    stream(69, cyc);
    out_ready = 1'b0;
    conv_valid = 1'b1;
    pixel_out = 48'h8000_8000_8000;
    repeat (3) step;
    conv_valid = 1'b0;
    chk("mid_ov", ov0, 1);
    chk("mid_x", x0, 5);
    chk("mid_y", y0, 2);
    chk("mid_cc", cc0, 9);
    rstb = 1'b1;
    step;
    rstb = 1'b0;
    chk("mrst_ov", ov0, 0);
    chk("mrst_wr", wr0, 1);
    chk("mrst_xy", {x0, y0}, 0);
    chk("mrst_cc", cc0, 0);
    chk("mrst_fd", fd0, 0);
    step;
    chk("mrst_fd2", fd0, 0);
    chk("mrst_ov2", ov0, 0);

    do_reset;
    nfd = 0;
    conv_valid = 1'b1;
    out_ready = 1'b1;
    pixel_out = 48'h8000_8000_8000;
    for (int i = 1; i <= 32768; i++) begin
      step;
      if (fds) nfd++;
      if (i == 100) chk("sat_cc100", ccs, 300);
      if (i == 30000) chk("sat_cc_max", ccs, 16'hFFFF);
    end
    conv_valid = 1'b0;
    chk("sat_no_fd", nfd, 0);
    chk("sat_last_x", xs, 127);
    chk("sat_last_y", ys, 255);
    chk("sat_hold", ccs, 16'hFFFF);
    chk("sat_last_ov", ovs, 1);
    step;
    chk("sat_fd", fds, 1);
    chk("sat_clr", ccs, 0);
    chk("sat_empty", ovs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_out_sat_fifo.md
Name: conv_out_sat_fifo

Overview:
- Stage directly downstream of the convolution stage. It consumes the 48-bit pixel_out word (three signed 16-bit channel results) under the conv_valid/write_ready handshake.
- Each channel is arithmetically scaled, then saturated to unsigned 8 bits and packed as 24-bit RGB.
- Results are buffered in a small FIFO and presented to the writer with valid/ready, raster coordinates, an end-of-frame pulse and a per-frame clip counter.

Parameters:
- WIDTH, 32, pixels per output row.
- HEIGHT, 32, rows per output frame.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SHIFT, 0, arithmetic right shift applied to each channel before saturation (0..8).

Ports:
- clk  input  1  rising-edge clock.
- rstb  input  1  reset; synchronous, active-high.
- conv_valid  input  1  upstream word valid.
- pixel_out  input  48  upstream word: R=[47:32], G=[31:16], B=[15:0], each two's-complement.
- write_ready  output  1  upstream ready; drives the convolution stage's write_ready.
- out_ready  input  1  downstream ready.
- out_valid  output  1  FIFO head valid.
- out_pixel  output  24  packed result: R=[23:16], G=[15:8], B=[7:0].
- out_x  output  $clog2(WIDTH)  column of the head pixel.
- out_y  output  $clog2(HEIGHT)  row of the head pixel.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is popped.
- clip_cnt  output  16  channels saturated in the current frame (saturating count).

Behaviour:
- Reset: clk and rstb (synchronous, active-high). While rstb=1 at a rising edge:
  - FIFO pointers and occupancy are cleared, so out_valid=0 and write_ready=1 on the following cycle.
  - out_pixel, out_x, out_y, frame_done and clip_cnt are all 0.
  - FIFO contents are don't-care.
- Reset mid-operation discards all buffered data and restarts coordinates at (0,0) with no frame_done.
- Push rule: push = conv_valid & write_ready.
- Pop rule: pop = out_valid & out_ready.
- write_ready = (occupancy != DEPTH), registered from occupancy. When full, write_ready stays 0 even if a pop occurs in the same cycle; there is no full-bypass.
- out_valid = (occupancy != 0). There is no empty-bypass: a word pushed in cycle N appears at the head with out_valid=1 in cycle N+1 at the earliest. Latency is 1 cycle.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally; occupancy is log2(DEPTH)+1 bits.
- The head entry (out_pixel) must stay stable while out_valid=1 and out_ready=0.
- Per-channel arithmetic at push time:
  - v = ch >>> SHIFT, 16-bit signed.
  - If v < 0, the result is 0.
  - If v > 255, the result is 255.
  - Otherwise the result is v[7:0].
- Clip counting:
  - Each saturated channel (either bound) adds 1 to clip_cnt, so 0..3 per push.
  - clip_cnt holds at 16'hFFFF.
- Coordinate counters (x,y) track the head pixel and advance on pop only:
  - x increments.
  - At x=WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0.
- Frame end:
  - Popping pixel (WIDTH-1, HEIGHT-1) sets frame_done=1 for exactly the next cycle.
  - That same pop clears clip_cnt to 0, ready for the next frame. Pushes in that cycle count toward the new frame.
  - The clip_cnt value is the frame total while the last pixel is at the head. The writer samples it with the final pop.
- Frame control: no stalls or bubbles are inserted between frames; back-to-back frames are supported.
- Upstream behaviour: conv_valid while write_ready=0 is ignored. The upstream holds its word until it is accepted.

Test Plan:
- Reset then single push of pixel_out=48'h0064_FF9C_0200 with SHIFT=0 → next cycle out_valid=1, out_pixel=24'h64_00_FF, clip_cnt=2, out_x=0, out_y=0.
- SHIFT=4, push R=16'h0FF0, G=16'h1000, B=16'h0008 → out_pixel=24'hFF_FF_00, clip_cnt=1 (only G=256 clips).
- out_ready=0 while pushing DEPTH=4 words → write_ready=0 after the 4th push, a 5th conv_valid is not accepted, and the head stays equal to word 0. Then out_ready=1 with conv_valid held → words pop in order and write_ready returns 1 the cycle after occupancy drops below 4.
- Continuous conv_valid=1 and out_ready=1 for 1024 words at WIDTH=HEIGHT=32 → throughput of 1 word/cycle after the first, out_x/out_y follow the raster order and wrap 31→0, and a single frame_done pulse appears the cycle after pop 1024.
- Assert rstb for 1 cycle with 3 words buffered at coordinate (5,2) → out_valid=0, write_ready=1, out_x=out_y=0, clip_cnt=0, and no frame_done.
- Push 30000 words with all channels at 16'h8000 → clip_cnt saturates at 16'hFFFF and returns to 0 only after the frame-end pop.
